// File: rtl/obi_sram_responder.sv
// OBI responder backed by a byte-lane SRAM, fixed read latency and an outstanding-transaction limit.
// Optional pseudo-random grant stalls are enabled by defining OBI_RESP_STALL_EN.

package obi_sram_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_sram_responder #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned SIZE_WORDS      = 1024,
   parameter int unsigned LATENCY         = 2,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] OOR_RDATA       = 32'hBADC_AB1E
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  obi_sram_pkg::obi_req_t   obi_req_i,
   output obi_sram_pkg::obi_resp_t  obi_resp_o,
   output logic [15:0]              oor_count_o,
   output logic                     busy_o
);

   localparam int unsigned    AW      = $clog2(SIZE_WORDS);
   localparam int unsigned    CW      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [32:0]    SPAN    = 33'(SIZE_WORDS) * 33'd4;
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [31:0]        off;
   logic               in_range;
   logic [AW-1:0]      widx;
   logic               stall;
   logic               rsp_fire;
   logic               gnt;
   logic               accept;
   logic [CW-1:0]      outst_q, outst_d;
   logic [15:0]        oor_q, oor_d;
   logic [LATENCY-1:0] vld_q;
   logic               rd_we_q, rd_oor_q;
   logic [31:0]        mem_rdata;
   logic [31:0]        s0_data;
   logic [31:0]        rsp_data;

   // Offset is taken modulo 2^32, so addresses below BASE_ADDR wrap high and decode as out of range.
   assign off      = obi_req_i.addr - BASE_ADDR;
   assign in_range = {1'b0, off} < SPAN;
   assign widx     = off[AW+1:2];

`ifdef OBI_RESP_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   // A response leaving this cycle frees a slot, so a full responder can still grant.
   assign rsp_fire = vld_q[LATENCY-1] & ~rst_i;
   assign gnt      = obi_req_i.req & ~rst_i & ~stall & ((outst_q < MAX_CNT) | rsp_fire);
   assign accept   = obi_req_i.req & gnt;

   always_comb begin
      outst_d = outst_q;
      if (accept & ~rsp_fire) begin
         outst_d = outst_q + CW'(1);
      end else if (~accept & rsp_fire) begin
         outst_d = outst_q - CW'(1);
      end
   end

   always_comb begin
      oor_d = oor_q;
      if (accept & ~in_range & (oor_q != 16'hFFFF)) begin
         oor_d = oor_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outst_q <= '0;
         oor_q   <= '0;
         vld_q   <= '0;
      end else begin
         outst_q  <= outst_d;
         oor_q    <= oor_d;
         vld_q[0] <= accept;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         rd_we_q  <= obi_req_i.we;
         rd_oor_q <= ~in_range;
      end
   end

   // One independent byte-wide array per lane keeps byte-enable writes inferable as block RAM.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [SIZE_WORDS];
         logic [7:0] rd_q;

         always_ff @(posedge clk_i) begin
            if (accept & in_range) begin
               if (obi_req_i.we) begin
                  if (obi_req_i.be[gi]) begin
                     lane_mem[widx] <= obi_req_i.wdata[8*gi +: 8];
                  end
               end else begin
                  rd_q <= lane_mem[widx];
               end
            end
         end

         assign mem_rdata[8*gi +: 8] = rd_q;
      end
   endgenerate

   always_comb begin
      s0_data = mem_rdata;
      if (rd_we_q) begin
         s0_data = 32'h0;
      end else if (rd_oor_q) begin
         s0_data = OOR_RDATA;
      end
   end

   generate
      if (LATENCY == 1) begin : g_dly_none
         assign rsp_data = s0_data;
      end else begin : g_dly
         logic [31:0] dly_q [LATENCY-1];

         always_ff @(posedge clk_i) begin
            dly_q[0] <= s0_data;
            for (int i = 1; i < LATENCY - 1; i++) begin
               dly_q[i] <= dly_q[i-1];
            end
         end

         assign rsp_data = dly_q[LATENCY-2];
      end
   endgenerate

   always_comb begin
      obi_resp_o        = '0;
      obi_resp_o.gnt    = gnt;
      obi_resp_o.rvalid = rsp_fire;
      obi_resp_o.rdata  = rsp_fire ? rsp_data : 32'h0;
   end

   assign oor_count_o = oor_q;
   assign busy_o      = (outst_q != '0);

endmodule

// File: tb/tb_obi_sram_responder.sv
// Self-checking bench: directed vectors, outstanding-limit sequence on a LATENCY=3 instance,
// mid-flight reset, and random traffic against a queue-based reference model.

module tb_obi_sram_responder;
   import obi_sram_pkg::*;

   localparam int          LAT  = 2;
   localparam int          MAXO = 2;
   localparam logic [31:0] OOR  = 32'hBADC_AB1E;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   obi_req_t    req2 = '0;
   obi_req_t    req3 = '0;
   obi_resp_t   resp2, resp3;
   logic [15:0] oor2, oor3;
   logic        busy2, busy3;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   obi_sram_responder #(
      .BASE_ADDR(32'h0), .SIZE_WORDS(1024), .LATENCY(2), .MAX_OUTSTANDING(2), .OOR_RDATA(OOR)
   ) dut (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req2), .obi_resp_o(resp2),
      .oor_count_o(oor2), .busy_o(busy2)
   );

   obi_sram_responder #(
      .BASE_ADDR(32'h0), .SIZE_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(2), .OOR_RDATA(OOR)
   ) dut3 (
      .clk_i(clk), .rst_i(rst), .obi_req_i(req3), .obi_resp_o(resp3),
      .oor_count_o(oor3), .busy_o(busy3)
   );

   // Reference model: word array, saturating counter, queue of responses with due cycles.
   typedef struct { int due; logic [31:0] data; } pend_t;
   pend_t       q[$];
   logic [31:0] mem_m [1024];
   logic [15:0] oor_m = '0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [15:0] exp_oor;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_access(input obi_req_t r);
      logic [31:0] off;
      int          idx;
      off = r.addr - 32'h0;
      if (off >= 32'd4096) begin
         if (oor_m != 16'hFFFF) oor_m = oor_m + 16'd1;
         return r.we ? 32'h0 : OOR;
      end
      idx = int'(off / 4);
      if (r.we) begin
         for (int b = 0; b < 4; b++)
            if (r.be[b]) mem_m[idx][8*b +: 8] = r.wdata[8*b +: 8];
         return 32'h0;
      end
      return mem_m[idx];
   endfunction

   task automatic drive_cycle(input obi_req_t r, output logic acc, output logic rv,
                              output logic [31:0] rd);
      logic        fire;
      logic        exp_gnt;
      logic [31:0] exp_rd;
      logic [31:0] d;
      @(negedge clk);
      rst  = 1'b0;
      req2 = r;
      #1;
      fire    = (q.size() != 0) && (q[0].due == cyc);
      exp_gnt = r.req && ((q.size() < MAXO) || fire);
      exp_rd  = fire ? q[0].data : 32'h0;
      chk("gnt",    32'(resp2.gnt),    32'(exp_gnt));
      chk("rvalid", 32'(resp2.rvalid), 32'(fire));
      chk("rdata",  resp2.rdata,       exp_rd);
      chk("busy",   32'(busy2),        32'(q.size() != 0));
      chk("oor",    32'(oor2),         32'(oor_m));
      if (fire) void'(q.pop_front());
      if (exp_gnt) begin
         d = model_access(r);
         q.push_back('{cyc + LAT, d});
      end
      acc = exp_gnt;
      rv  = resp2.rvalid;
      rd  = resp2.rdata;
   endtask

   task automatic do_reset(input int n, input logic hold_req);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst      = 1'b1;
         req2     = '0;
         req2.req = hold_req;
         req3     = req2;
         #1;
         chk("rst_gnt",     32'(resp2.gnt),    0);
         chk("rst_rvalid",  32'(resp2.rvalid), 0);
         chk("rst_rdata",   resp2.rdata,       0);
         chk("rst_gnt_l3",  32'(resp3.gnt),    0);
         if (i > 0) begin
            chk("rst_busy", 32'(busy2), 0);
            chk("rst_oor",  32'(oor2),  0);
         end
      end
      req3 = '0;
      q.delete();
      oor_m = '0;
   endtask

   task automatic xact(input obi_req_t r, output logic [31:0] rd);
      logic        acc, rv;
      logic [31:0] d;
      obi_req_t    idle;
      int          t, acc_cyc;
      idle = '0;
      acc  = 1'b0;
      t    = 0;
      while (!acc && t < 20) begin
         drive_cycle(r, acc, rv, d);
         t++;
      end
      acc_cyc = cyc;
      rv = 1'b0;
      t  = 0;
      while (!rv && t < 10) begin
         drive_cycle(idle, acc, rv, d);
         t++;
      end
      chk("rsp_latency", 32'(cyc - acc_cyc), 32'(LAT));
      rd = d;
   endtask

   function automatic obi_req_t mk(input logic we, input logic [31:0] a, input logic [3:0] be,
                                   input logic [31:0] wd);
      obi_req_t r;
      r.req = 1'b1; r.we = we; r.addr = a; r.be = be; r.wdata = wd;
      return r;
   endfunction

   initial begin
      vec_t        vecs[10];
      int          gpat[12];
      logic        gobs[12], vobs[12];
      logic [31:0] dobs[12];
      logic [31:0] got;
      logic        acc, rv;
      logic [31:0] d;
      obi_req_t    r;

      vecs[0] = '{1'b1, 32'h10,       4'hF, 32'h1234_5678, 32'h0,         16'd0};
      vecs[1] = '{1'b0, 32'h10,       4'hF, 32'h0,         32'h1234_5678, 16'd0};
      vecs[2] = '{1'b1, 32'h20,       4'hF, 32'hFFFF_FFFF, 32'h0,         16'd0};
      vecs[3] = '{1'b1, 32'h20,       4'h1, 32'h0000_00AA, 32'h0,         16'd0};
      vecs[4] = '{1'b0, 32'h20,       4'hF, 32'h0,         32'hFFFF_FFAA, 16'd0};
      vecs[5] = '{1'b0, 32'h1000,     4'hF, 32'h0,         32'hBADC_AB1E, 16'd1};
      vecs[6] = '{1'b1, 32'h1000,     4'hF, 32'hDEAD_BEEF, 32'h0,         16'd2};
      vecs[7] = '{1'b0, 32'h0,        4'hF, 32'h0,         32'hA500_0000, 16'd2};
      vecs[8] = '{1'b0, 32'h13,       4'h0, 32'h0,         32'h1234_5678, 16'd2};
      vecs[9] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,        32'hBADC_AB1E, 16'd3};
      gpat = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};

      // Reset with req held high.
      do_reset(4, 1'b1);

      // Outstanding limit on the LATENCY=3 / MAX_OUTSTANDING=2 instance.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst  = 1'b0;
         req2 = '0;
         req3 = (i < 8) ? mk(1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'(i)) : '0;
         #1;
         gobs[i] = resp3.gnt;
         vobs[i] = resp3.rvalid;
         dobs[i] = resp3.rdata;
      end
      req3 = '0;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("l3_gnt%0d", i),    32'(gobs[i]), 32'(gpat[i]));
         chk($sformatf("l3_rvalid%0d", i), 32'(vobs[i]), (i >= 3) ? 32'(gpat[i-3]) : 32'h0);
         chk($sformatf("l3_rdata%0d", i),  dobs[i], 32'h0);
      end
      chk("l3_busy_end", 32'(busy3), 0);

      // Known contents for words 0..15.
      for (int i = 0; i < 16; i++) begin
         xact(mk(1'b1, 32'(4 * i), 4'hF, 32'hA500_0000 | 32'(i)), got);
         chk("prefill_rdata", got, 32'h0);
      end

      for (int i = 0; i < 10; i++) begin
         xact(mk(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata), got);
         chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_oor", i), 32'(oor2), 32'(vecs[i].exp_oor));
      end

      // Reset with two reads in flight: their responses must vanish.
      drive_cycle(mk(1'b0, 32'h10, 4'hF, 32'h0), acc, rv, d);
      drive_cycle(mk(1'b0, 32'h20, 4'hF, 32'h0), acc, rv, d);
      do_reset(2, 1'b0);
      for (int i = 0; i < 4; i++) drive_cycle('0, acc, rv, d);
      chk("midrst_busy", 32'(busy2), 0);
      xact(mk(1'b0, 32'h10, 4'hF, 32'h0), got);
      chk("midrst_read", got, 32'h1234_5678);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         r.req   = ($urandom_range(0, 9) < 7);
         r.we    = $urandom_range(0, 1) == 1;
         r.be    = 4'($urandom_range(0, 15));
         r.wdata = $urandom;
         if ($urandom_range(0, 9) < 8)
            r.addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         else
            r.addr = 32'h1000 + $urandom_range(0, 32'h7FFF_0000);
         drive_cycle(r, acc, rv, d);
      end
      for (int i = 0; i < 6; i++) drive_cycle('0, acc, rv, d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/obi_sram_responder.md
Name: obi_sram_responder

Overview:
- OBI responder (slave) terminating one core instruction or data port of the triple-core cpu_system. Each core port gets its own instance.
- Accepts obi_req_t transactions and returns obi_resp_t with a fixed, parameterised read latency.
- Backs the port with a local word-addressed SRAM array.
- Enforces an outstanding-transaction limit, and supports byte-enable writes and out-of-range address handling.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- SIZE_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- LATENCY, 2, cycles from grant to rvalid; legal range 1..4.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; legal range 1..LATENCY.
- OOR_RDATA, 32'hBADC_AB1E, read data returned for out-of-range addresses.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- obi_req_i  input  obi_req_t  OBI request: req, addr, we, be, wdata.
- obi_resp_o  output  obi_resp_t  OBI response: gnt, rvalid, rdata.
- oor_count_o  output  16  saturating count of out-of-range accesses.
- busy_o  output  1  high while outstanding count is non-zero.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - gnt = 0, rvalid = 0, rdata = 0.
  - oor_count_o = 0, busy_o = 0.
  - Outstanding counter = 0; all pipeline valid bits = 0.
  - SRAM contents are not reset.
- Grant (combinational):
  - gnt = req & ~rst_i & (outstanding_q < MAX_OUTSTANDING | rsp_fire), where rsp_fire = rvalid this cycle.
  - gnt does not depend on we or addr.
- Acceptance: a transaction is accepted on a cycle with req & gnt.
- Address decode:
  - off = addr - BASE_ADDR, computed modulo 2^32.
  - In range iff off < SIZE_WORDS*4. Word index = off[log2(SIZE_WORDS)+1:2].
  - addr[1:0] is ignored.
- Write accepted:
  - If in range, each byte lane i with be[i]=1 is written from wdata[8i+7:8i] at the acceptance clock edge.
  - Response data = 32'h0.
- Read accepted:
  - SRAM is read at the acceptance cycle, returning post-write state of all earlier accepted writes.
  - Response data = word if in range, else OOR_RDATA.
- Out-of-range access (read or write):
  - No SRAM update.
  - oor_count_o increments, saturating at 16'hFFFF.
- Response pipeline:
  - Shift register of LATENCY stages, each holding {valid, data}. Stage 0 is loaded on acceptance.
  - Stages advance every cycle, unconditionally; OBI has no response backpressure.
  - rvalid/rdata come from the last stage. rdata = 0 when rvalid = 0.
  - Latency: acceptance at cycle N gives rvalid at cycle N+LATENCY, for exactly one cycle.
- Ordering: responses are strictly in acceptance order. Back-to-back acceptances give back-to-back rvalids.
- Outstanding counter:
  - +1 on acceptance, -1 on rvalid; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING, never underflows.
- busy_o = (outstanding_q != 0).
- Throughput:
  - MAX_OUTSTANDING = LATENCY gives one transaction per cycle sustained.
  - Smaller values throttle gnt.
- Request changes: req may drop or change while gnt is low; the responder holds no state for ungranted requests.
- Reset mid-operation: all in-flight responses are discarded, no rvalid is produced for them, and the counter clears. SRAM writes already committed persist.

Optional Feature:
- Macro: OBI_RESP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - gnt is additionally masked when lfsr[0]=1. This inserts pseudo-random grant stalls for exercising the core's wait handling.
  - Latency from acceptance is unchanged.
- When undefined: no LFSR logic is present and gnt follows the base rule only.

Test Plan:
- Reset then idle, LATENCY=2: hold rst_i 3 cycles with req=1 → gnt=0 throughout reset, rvalid=0, oor_count_o=0, busy_o=0.
- Write/read, LATENCY=2: write addr 0x10, be=4'b1111, wdata=0x1234_5678; then read 0x10 → write rvalid at accept+2 with rdata=0; read rvalid at accept+2 with rdata=0x1234_5678.
- Byte enables: write 0x20 with 0xFFFF_FFFF/be=4'hF, then 0x0000_00AA/be=4'b0001; read 0x20 → 0xFFFF_FFAA.
- Outstanding limit, LATENCY=3, MAX_OUTSTANDING=2: req held high 8 cycles → gnt pattern 1,1,0,1,1,0,1,1; exactly one rvalid per grant, each 3 cycles after its grant.
- Out of range, SIZE_WORDS=1024, BASE_ADDR=0: read 0x1000 → rdata=0xBADC_AB1E, oor_count_o=1. Write 0x1000 then read 0x0 → word 0 unchanged, oor_count_o=2.
- Reset mid-flight: accept two reads, assert rst_i the next cycle → no rvalid for either read, busy_o=0 after reset, a subsequent read returns correct data.
